// File: rtl/spi_slave_pkg.sv
// Shared types and helpers for the SPI slave front end: lane-mode encoding
// and the mapping from a requested lane mode to the active lane count.
package spi_slave_pkg;

  typedef enum logic [1:0] {
    LANE_X1 = 2'b00,
    LANE_X2 = 2'b01,
    LANE_X4 = 2'b10
  } lane_mode_e;

  // Unsupported codes and modes wider than the physical pins fall back to x1.
  function automatic logic [2:0] lane_count(input lane_mode_e mode, input int lanes);
    logic [2:0] n;
    case (mode)
      LANE_X1: n = 3'd1;
      LANE_X2: n = 3'd2;
      LANE_X4: n = 3'd4;
      default: n = 3'd1;
    endcase
    if (int'(n) > lanes) begin
      n = 3'd1;
    end else begin
      n = n;
    end
    return n;
  endfunction

endpackage

// File: rtl/spi_slave_tx_buf.sv
// One-entry valid/ready holding register used as the TX prefetch stage.
// A push and a pop in the same cycle replace the held word.
module spi_slave_tx_buf #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  logic                  full;
  logic [DATA_WIDTH-1:0] hold;

  assign in_ready  = ~full | out_ready;
  assign out_data  = hold;
  assign out_valid = full;

  // Holding register and occupancy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      hold <= '0;
    end else if (in_valid && in_ready) begin
      full <= 1'b1;
      hold <= in_data;
    end else if (full && out_ready) begin
      full <= 1'b0;
    end else begin
      full <= full;
    end
  end

endmodule

// File: rtl/spi_slave_tx_lanes.sv
// SPI slave transmitter over 1/2/4 lanes, MSB first, multi-word streaming.
// Define SPI_SLAVE_TX_PREFETCH_EN to add the one-word prefetch buffer.
module spi_slave_tx_lanes
  import spi_slave_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  sclk,
  input  logic                  cs,
  input  logic [1:0]            lane_mode,
  input  logic [CNT_WIDTH-1:0]  counter_in,
  input  logic                  counter_in_upd,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic [LANES-1:0]      miso,
  output logic [LANES-1:0]      miso_oe,
  output logic                  done,
  output logic                  underrun
);

  localparam int WCW = $clog2(DATA_WIDTH);
  localparam logic [WCW-1:0] LAST_X1 = WCW'(DATA_WIDTH - 1);
  localparam logic [WCW-1:0] LAST_X2 = WCW'(DATA_WIDTH / 2 - 1);
  localparam logic [WCW-1:0] LAST_X4 = WCW'(DATA_WIDTH / 4 - 1);

  logic [DATA_WIDTH-1:0] sreg;
  logic [WCW-1:0]        wcnt;
  logic [CNT_WIDTH-1:0]  counter;
  logic [CNT_WIDTH-1:0]  target;
  logic                  running;
  logic [2:0]            k;

  logic                  ld;
  logic                  last_beat;
  logic [WCW-1:0]        wpb_last;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] load_word;
  logic                  underrun_set;
  logic                  buf_full;
  logic [DATA_WIDTH-1:0] buf_data;
  logic [3:0]            grp;
  logic [3:0]            mask;

  assign last_beat = running & (counter == target);
  assign ld        = counter_in_upd | (running & (wcnt == wpb_last) & ~last_beat);

`ifdef SPI_SLAVE_TX_PREFETCH_EN
  logic buf_in_valid;
  logic buf_in_ready;

  // A word arriving on a load edge with an empty buffer bypasses it.
  assign buf_in_valid = data_valid & ~(ld & ~buf_full);
  assign data_ready   = ~cs & buf_in_ready;

  spi_slave_tx_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk      (sclk),
    .rst      (cs),
    .in_data  (data),
    .in_valid (buf_in_valid),
    .in_ready (buf_in_ready),
    .out_data (buf_data),
    .out_valid(buf_full),
    .out_ready(ld)
  );
`else
  assign buf_full   = 1'b0;
  assign buf_data   = '0;
  assign data_ready = ~cs & ld;
`endif

  // Per-lane-mode word length and shift step.
  always_comb begin
    wpb_last = LAST_X1;
    shifted  = sreg << 3'd1;
    case (k)
      3'd4: begin
        wpb_last = LAST_X4;
        shifted  = sreg << 3'd4;
      end
      3'd2: begin
        wpb_last = LAST_X2;
        shifted  = sreg << 3'd2;
      end
      default: begin
        wpb_last = LAST_X1;
        shifted  = sreg << 3'd1;
      end
    endcase
  end

  // Source select for the shift register on a load edge.
  always_comb begin
    load_word    = '0;
    underrun_set = 1'b0;
    if (buf_full) begin
      load_word = buf_data;
    end else if (data_valid) begin
      load_word = data;
    end else begin
      load_word    = '0;
      underrun_set = 1'b1;
    end
  end

  // Lane drive: top k bits of the shift register, inactive lanes held low.
  always_comb begin
    grp  = 4'b0000;
    mask = 4'b0001;
    case (k)
      3'd4: begin
        grp  = sreg[DATA_WIDTH-1 -: 4];
        mask = 4'b1111;
      end
      3'd2: begin
        grp  = {2'b00, sreg[DATA_WIDTH-1 -: 2]};
        mask = 4'b0011;
      end
      default: begin
        grp  = {3'b000, sreg[DATA_WIDTH-1]};
        mask = 4'b0001;
      end
    endcase
  end

  assign miso    = grp[LANES-1:0];
  assign miso_oe = running ? mask[LANES-1:0] : '0;

  // Beat counting, transfer control, shift register and underrun flag.
  always_ff @(posedge sclk) begin
    if (cs) begin
      sreg     <= '0;
      wcnt     <= '0;
      counter  <= '0;
      target   <= CNT_WIDTH'(8'd7);
      running  <= 1'b0;
      k        <= 3'd1;
      done     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (counter_in_upd) begin
        target  <= counter_in;
        counter <= '0;
        running <= 1'b1;
        k       <= lane_count(lane_mode_e'(lane_mode), LANES);
        done    <= last_beat;
      end else if (last_beat) begin
        running <= 1'b0;
        counter <= '0;
        done    <= 1'b1;
      end else if (running) begin
        counter <= counter + CNT_WIDTH'(1'b1);
        done    <= 1'b0;
      end else begin
        done    <= 1'b0;
      end

      if (ld) begin
        sreg <= load_word;
        wcnt <= '0;
        if (underrun_set) begin
          underrun <= 1'b1;
        end else begin
          underrun <= underrun;
        end
      end else if (running) begin
        sreg <= shifted;
        wcnt <= wcnt + WCW'(1'b1);
      end else begin
        sreg <= sreg;
      end
    end
  end

endmodule
